// File: rtl/write_controller.sv
`default_nettype none
// ============================================================================
// Module   : write_controller
// Brief    : Packs three UART bytes into a 24-bit pixel and writes it to
//            pixel memory at a wrapping address.
// Revision : 1.0 - initial release
// ============================================================================
module write_controller #(
    parameter int NUM_PIXELS = 199692
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_received,
    input  logic        rx_data_ready,
    output logic        en,
    output logic        we,
    output logic [17:0] addr,
    output logic [23:0] din,
    output logic [2:0]  status,
    output logic [2:0]  status_next,
    output logic [23:0] array,
    output logic [1:0]  byte_counter
);

    localparam logic [2:0]  c_IDLE      = 3'd0;
    localparam logic [2:0]  c_WRITE     = 3'd1;
    localparam logic [2:0]  c_NEXT_ADDR = 3'd2;
    localparam logic [17:0] c_LAST_ADDR = 18'(NUM_PIXELS - 1);

    logic [2:0]  r_status;
    logic [17:0] r_addr;
    logic [23:0] r_array;
    logic [1:0]  r_byte_counter;

    logic [2:0]  w_status_next;
    logic        w_capture;
    logic        w_last_byte;

    // Strobes outside IDLE are dropped: the pixel is already committed.
    assign w_capture   = (r_status == c_IDLE) && rx_data_ready;
    assign w_last_byte = (r_byte_counter == 2'd2);

    always_comb begin
        w_status_next = c_IDLE;
        if (!rst) begin
            case (r_status)
                c_IDLE:      w_status_next = (w_capture && w_last_byte) ? c_WRITE : c_IDLE;
                c_WRITE:     w_status_next = c_NEXT_ADDR;
                c_NEXT_ADDR: w_status_next = c_IDLE;
                default:     w_status_next = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status       <= c_IDLE;
            r_addr         <= 18'd0;
            r_array        <= 24'd0;
            r_byte_counter <= 2'd0;
        end else begin
            r_status <= w_status_next;

            if (w_capture) begin
                r_array        <= {r_array[15:0], byte_received};
                r_byte_counter <= w_last_byte ? 2'd0 : r_byte_counter + 2'd1;
            end

            if (r_status == c_NEXT_ADDR) begin
                r_addr <= (r_addr == c_LAST_ADDR) ? 18'd0 : r_addr + 18'd1;
            end
        end
    end

    // Moore outputs: the write strobe depends on the state register alone.
    assign en           = (r_status == c_WRITE);
    assign we           = en;
    assign addr         = r_addr;
    assign array        = r_array;
    assign din          = r_array;
    assign status       = r_status;
    assign status_next  = w_status_next;
    assign byte_counter = r_byte_counter;

endmodule
`default_nettype wire

// File: tb/tb_write_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_controller
// Brief    : Randomized bench for write_controller against a pixel-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_controller;

    localparam int NUM_PIXELS = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_received;
    logic        rx_data_ready;
    logic        en;
    logic        we;
    logic [17:0] addr;
    logic [23:0] din;
    logic [2:0]  status;
    logic [2:0]  status_next;
    logic [23:0] array;
    logic [1:0]  byte_counter;

    int checks   = 0;
    int failures = 0;

    // Reference model: pixel-level view of the stream.
    int          m_bytes;      // bytes held for the pixel being assembled
    int          m_pixels;     // pixels written since reset
    int          m_busy;       // cycles left in the write/advance phase (2 = write cycle)
    logic [23:0] m_arr;        // last three accepted bytes, oldest in the top byte

    write_controller #(
        .NUM_PIXELS(NUM_PIXELS)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .byte_received(byte_received),
        .rx_data_ready(rx_data_ready),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .din          (din),
        .status       (status),
        .status_next  (status_next),
        .array        (array),
        .byte_counter (byte_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        if (m_busy == 2) return 32'd1;
        if (m_busy == 1) return 32'd2;
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_next_status(input bit s);
        if (m_busy == 2) return 32'd2;
        if (m_busy == 1) return 32'd0;
        return (s && m_bytes == 2) ? 32'd1 : 32'd0;
    endfunction

    task automatic model_step(input bit s, input logic [7:0] d);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_pixels++;
        end else if (s) begin
            m_arr = {m_arr[15:0], d};
            m_bytes++;
            if (m_bytes == 3) begin
                m_bytes = 0;
                m_busy  = 2;
            end
        end
    endtask

    task automatic compare_model(input bit s);
        check_val("status",       32'(status),       model_status());
        check_val("status_next",  32'(status_next),  model_next_status(s));
        check_val("en",           32'(en),           32'(m_busy == 2));
        check_val("we",           32'(we),           32'(m_busy == 2));
        check_val("addr",         32'(addr),         32'(m_pixels % NUM_PIXELS));
        check_val("array",        32'(array),        32'(m_arr));
        check_val("din",          32'(din),          32'(m_arr));
        check_val("byte_counter", 32'(byte_counter), 32'(m_bytes));
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input bit s, input logic [7:0] d);
        rx_data_ready = s;
        byte_received = d;
        #1;
        compare_model(s);
        @(posedge clk);
        model_step(s, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    // Asserted mid-cycle so outputs must clear without a clock edge.
    task automatic do_reset();
        rst           = 1'b1;
        rx_data_ready = 1'b0;
        byte_received = 8'h00;
        #1;
        check_val("rst_status",      32'(status),       32'd0);
        check_val("rst_status_next", 32'(status_next),  32'd0);
        check_val("rst_addr",        32'(addr),         32'd0);
        check_val("rst_array",       32'(array),        32'd0);
        check_val("rst_din",         32'(din),          32'd0);
        check_val("rst_byte_cnt",    32'(byte_counter), 32'd0);
        check_val("rst_en",          32'(en),           32'd0);
        check_val("rst_we",          32'(we),           32'd0);
        @(posedge clk);
        m_bytes  = 0;
        m_pixels = 0;
        m_busy   = 0;
        m_arr    = 24'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_spaced(input logic [7:0] d, input int gap);
        cycle(1'b1, d);
        idle(gap - 1);
    endtask

    initial begin
        rst           = 1'b1;
        rx_data_ready = 1'b0;
        byte_received = 8'h00;
        m_bytes       = 0;
        m_pixels      = 0;
        m_busy        = 0;
        m_arr         = 24'd0;
        @(negedge clk);
        do_reset();

        // Spaced bytes forming one pixel at address 0.
        send_spaced(8'h01, 6);
        send_spaced(8'h02, 6);
        send_spaced(8'h03, 6);
        check_val("first_pixel_addr_after", 32'(addr), 32'd1);

        // Level-held strobe: one byte per cycle.
        cycle(1'b1, 8'h04);
        cycle(1'b1, 8'h05);
        cycle(1'b1, 8'h06);
        idle(4);

        // Partial pixel discarded by reset.
        send_spaced(8'h11, 4);
        send_spaced(8'h22, 4);
        do_reset();
        send_spaced(8'hAA, 4);
        send_spaced(8'hBB, 4);
        send_spaced(8'hCC, 4);

        // Strobe landing in the write cycle is dropped.
        cycle(1'b1, 8'h31);
        cycle(1'b1, 8'h32);
        cycle(1'b1, 8'h33);
        cycle(1'b1, 8'h99);
        idle(3);

        // Reset while the write strobe is high.
        cycle(1'b1, 8'h41);
        cycle(1'b1, 8'h42);
        cycle(1'b1, 8'h43);
        do_reset();

        // Fifteen bytes: five pixels across the address wrap.
        for (int i = 0; i < 15; i++) send_spaced(8'(8'h50 + i), 3);
        check_val("wrap_addr_after", 32'(addr), 32'(5 % NUM_PIXELS));

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle($urandom_range(0, 99) < 45, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/write_controller.md
WRITE_CONTROLLER -- requirements
Module: write_controller

Interface
REQ-001 Parameter: NUM_PIXELS, 199692, number of 24-bit pixels per image; legal range 1..262144.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 byte_received  input  8  byte from UART receiver; valid only while rx_data_ready=1.
REQ-006 rx_data_ready  input  1  one-cycle strobe: byte_received is valid this cycle.
REQ-007 en  output  1  memory enable, high only during a pixel write cycle.
REQ-008 we  output  1  memory write enable, identical to en.
REQ-009 addr  output  18  memory write address (pixel index).
REQ-010 din  output  24  memory write data; always equal to array.
REQ-011 status  output  3  current FSM state (debug).
REQ-012 status_next  output  3  combinational next FSM state (debug).
REQ-013 array  output  24  pixel assembly register (debug).
REQ-014 byte_counter  output  2  bytes captured in current pixel, 0..2 (3 transient in same edge as transition to WRITE not allowed; see REQ-018).

Function
REQ-015 FSM states SHALL be encoded IDLE=3'd0, WRITE=3'd1, NEXT_ADDR=3'd2; codes 3..7 SHALL go to IDLE next cycle.
REQ-016 IDLE: on rx_data_ready=1, array <= {array[15:0], byte_received} (first byte of a pixel ends in [23:16], third in [7:0]).
REQ-017 IDLE with rx_data_ready=1 and byte_counter<2: byte_counter <= byte_counter+1, stay IDLE.
REQ-018 IDLE with rx_data_ready=1 and byte_counter==2: byte_counter <= 0, next state WRITE.
REQ-019 WRITE: en=we=1 for exactly this one cycle, addr and din stable; next state NEXT_ADDR unconditionally.
REQ-020 NEXT_ADDR: addr <= addr+1, or 0 when addr==NUM_PIXELS-1 (wrap); next state IDLE.
REQ-021 en and we SHALL be decoded from status only (Moore), 0 in every state except WRITE.
REQ-022 Write latency: en/we high in the cycle after the edge that captured the third byte.
REQ-023 rx_data_ready asserted in WRITE or NEXT_ADDR SHALL be ignored (byte dropped, array and byte_counter unchanged); upstream guarantees ≥3 cycles between strobes.
REQ-024 rx_data_ready held high several cycles in IDLE SHALL capture one byte per cycle (level-sensitive).
REQ-025 status_next SHALL equal the value status takes at the next rising edge absent reset.
REQ-026 din SHALL be a continuous copy of array (no extra register).

Reset
REQ-027 While rst=1: status=IDLE, status_next=IDLE, addr=0, array=0, byte_counter=0, en=we=0, din=0, immediately without a clock edge.
REQ-028 Reset mid-pixel or mid-write SHALL discard partial bytes; after release the next three bytes form a pixel at addr 0.

Verification
REQ-029 Reset, bytes 0x01,0x02,0x03 (strobes 6 cycles apart) -> one cycle en=we=1, addr=0, din=0x010203; then addr=1, status=IDLE.
REQ-030 Incrementing byte stream 0x01..0x06 -> writes 0x010203 @0 and 0x040506 @1, exactly two en pulses.
REQ-031 Two bytes then rst pulse, then 0xAA,0xBB,0xCC -> write din=0xAABBCC at addr 0; no write before reset.
REQ-032 NUM_PIXELS=4, send 15 bytes -> writes at addr 0,1,2,3,0; addr wraps to 0 after 3.
REQ-033 Strobe asserted during WRITE cycle -> byte ignored, byte_counter stays 0, array unchanged.
REQ-034 Every cycle: status_next equals next-cycle status; en==we; din==array.
